zprize_mul_kara_pipe: RTL

ZPRIZE_MUL_KARA_PIPE -- requirements
Module: zprize_mul_kara_pipe

---
 rtl/zprize_mul_pkg.sv | 16 +
 rtl/zprize_mul_leaf.sv | 41 ++++
 rtl/zprize_mul_kara_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/zprize_mul_pkg.sv
// Shared sizing helpers for the one-level Karatsuba multiplier pipeline.
package zprize_mul_pkg;

    function automatic int kara_lat(input int leaf_lat);
        return leaf_lat + 3;
    endfunction

    function automatic int kara_w2(input int w);
        return (w + 1) / 2;
    endfunction

    function automatic int kara_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/zprize_mul_leaf.sv
// Pipelined unsigned W x W multiplier with clock enable; metadata rides alongside the product.
module zprize_mul_leaf #(
    parameter int W   = 16,
    parameter int LAT = 4,
    parameter int M   = 1
) (
    input  logic           clk,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [M-1:0]   meta_i,
    output logic [2*W-1:0] p,
    output logic [M-1:0]   meta_o
);

    logic [LAT-1:0][2*W-1:0] p_d, p_q;
    logic [LAT-1:0][M-1:0]   meta_d, meta_q;

    always_comb begin
        p_d    = p_q;
        meta_d = meta_q;
        if (en) begin
            p_d[0]    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            meta_d[0] = meta_i;
            for (int i = 1; i < LAT; i++) begin
                p_d[i]    = p_q[i-1];
                meta_d[i] = meta_q[i-1];
            end
        end
    end

    // Pure datapath: no reset, validity is tracked by the parent.
    always_ff @(posedge clk) begin
        p_q    <= p_d;
        meta_q <= meta_d;
    end

    assign p      = p_q[LAT-1];
    assign meta_o = meta_q[LAT-1];

endmodule

// File: rtl/zprize_mul_kara_pipe.sv
// One-level Karatsuba W x W multiplier, LEAF_LAT+3 cycles, valid/ready with global stall.
// Optional square mode (sqr port) enabled by defining ZPRIZE_MUL_SQR_EN.
module zprize_mul_kara_pipe
    import zprize_mul_pkg::*;
#(
    parameter int W        = 384,
    parameter int LEAF_LAT = 4,
    parameter int M        = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [W-1:0]                              in0,
    input  logic [W-1:0]                              in1,
`ifdef ZPRIZE_MUL_SQR_EN
    input  logic                                      sqr,
`endif
    input  logic [M-1:0]                              m_i,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [2*W-1:0]                            out0,
    output logic [M-1:0]                              m_o,
    output logic [kara_cnt_w(kara_lat(LEAF_LAT))-1:0] inflight
);

    localparam int LAT = kara_lat(LEAF_LAT);
    localparam int W2  = kara_w2(W);
    localparam int XW  = 2 * W2;
    localparam int OW  = 2 * W;
    localparam int CW  = kara_cnt_w(LAT);

    logic          advance;
    logic [LAT-1:0] vld_d, vld_q;
    logic [CW-1:0] inflight_d, inflight_q;

    logic [XW-1:0] x_ext, y_ext;
    logic [W2-1:0] x0_d, x1_d, y0_d, y1_d, x0_q, x1_q, y0_q, y1_q;
    logic [W2:0]   a_d, b_d, a_q, b_q;
    logic [M-1:0]  meta_s0_q, meta_lf, meta_z_q, m_o_q;

    logic [XW-1:0]   m0_p, m2_p;
    logic [XW+1:0]   m1_p;
    logic            m2_meta_o, m1_meta_unused, sqr_s0_d, sqr_s0_q;

    logic [XW-1:0]   z0_d, z2_d, z0_q, z2_q;
    logic [XW+1:0]   z1_d, z1_q;
    logic [OW-1:0]   out0_d, out0_q;

    // The whole pipe moves together; a held output freezes every stage.
    assign advance   = !vld_q[LAT-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[LAT-1];
    assign out0      = out0_q;
    assign m_o       = m_o_q;
    assign inflight  = inflight_q;

    always_comb begin
        x_ext = XW'(in0);
`ifdef ZPRIZE_MUL_SQR_EN
        y_ext    = sqr ? XW'(in0) : XW'(in1);
        sqr_s0_d = sqr;
`else
        y_ext    = XW'(in1);
        sqr_s0_d = 1'b0;
`endif
        x0_d = x_ext[W2-1:0];
        x1_d = x_ext[XW-1:W2];
        y0_d = y_ext[W2-1:0];
        y1_d = y_ext[XW-1:W2];
        a_d  = {1'b0, x0_d} + {1'b0, x1_d};
        b_d  = {1'b0, y0_d} + {1'b0, y1_d};
    end

    always_comb begin
        z0_d = m0_p;
        z2_d = m2_p;
        // (x0+x1)(y0+y1) - x0y0 - x1y1 = x0y1 + x1y0, never negative.
        z1_d = m1_p - {2'b00, m0_p} - {2'b00, m2_p};
        out0_d = (OW'(z2_q) << XW) + (OW'(z1_q) << W2) + OW'(z0_q);
    end

    always_comb begin
        vld_d      = vld_q;
        inflight_d = inflight_q;
        if (advance)
            vld_d = {vld_q[LAT-2:0], in_valid};
        if ((in_valid && advance) && !(out_valid && out_ready))
            inflight_d = inflight_q + CW'(1);
        else if (!(in_valid && advance) && (out_valid && out_ready))
            inflight_d = inflight_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            a_q       <= a_d;
            b_q       <= b_d;
            meta_s0_q <= m_i;
            sqr_s0_q  <= sqr_s0_d;
            z0_q      <= z0_d;
            z1_q      <= z1_d;
            z2_q      <= z2_d;
            meta_z_q  <= meta_lf;
            out0_q    <= out0_d;
            m_o_q     <= meta_z_q;
        end
    end

    zprize_mul_leaf #(.W(W2), .LAT(LEAF_LAT), .M(M)) u_m0 (
        .clk(clk), .en(advance), .a(x0_q), .b(y0_q),
        .meta_i(meta_s0_q), .p(m0_p), .meta_o(meta_lf)
    );

    zprize_mul_leaf #(.W(W2), .LAT(LEAF_LAT), .M(1)) u_m2 (
        .clk(clk), .en(advance), .a(x1_q), .b(y1_q),
        .meta_i(sqr_s0_q), .p(m2_p), .meta_o(m2_meta_o)
    );

    zprize_mul_leaf #(.W(W2+1), .LAT(LEAF_LAT), .M(1)) u_m1 (
        .clk(clk), .en(advance), .a(a_q), .b(b_q),
        .meta_i(1'b0), .p(m1_p), .meta_o(m1_meta_unused)
    );

`ifdef ZPRIZE_MUL_SQR_EN
    // Per-beat square flag follows its beat to the output stage.
    logic sqr_z_q, sqr_o_q, sqr_o_unused;
    always_ff @(posedge clk) begin
        if (advance) begin
            sqr_z_q <= m2_meta_o;
            sqr_o_q <= sqr_z_q;
        end
    end
    assign sqr_o_unused = sqr_o_q;
`else
    logic m2_meta_unused;
    assign m2_meta_unused = m2_meta_o;
`endif

endmodule
